// File: rtl/pim_pkg.sv
// Shared definitions for the PIM command queue: funct3 opcodes, the 52-bit
// command record, the issue FSM state encoding and the command legality rule.
package pim_pkg;

  localparam logic [2:0] F3_WRITE   = 3'b001;
  localparam logic [2:0] F3_COMPUTE = 3'b010;
  localparam logic [2:0] F3_LOAD    = 3'b100;
  localparam logic [2:0] F3_KEY     = 3'b101;
  localparam logic [2:0] F3_VREF    = 3'b110;

  localparam int CMD_W = 52;

  typedef struct packed {
    logic [2:0]  funct3;
    logic [3:0]  sel_pim;
    logic [12:0] size;
    logic [31:0] mem_addr;
  } pim_cmd_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } pim_state_t;

  // A command is legal only with a known opcode and a non-zero transfer size.
  function automatic logic pim_cmd_legal(input logic [2:0] funct3, input logic [12:0] size);
    logic op_ok;
    case (funct3)
      F3_WRITE, F3_COMPUTE, F3_LOAD, F3_KEY, F3_VREF: op_ok = 1'b1;
      default:                                        op_ok = 1'b0;
    endcase
    return op_ok && (size != 13'd0);
  endfunction

endpackage

// File: rtl/pim_cmd_fifo.sv
// Synchronous show-ahead FIFO with registered occupancy count.
// Ports:
//   i_clk, i_rst      clock, synchronous active-high reset
//   i_push, i_wdata   write strobe and data (ignored when full)
//   i_pop             read strobe (ignored when empty); o_rdata shows the head
//   o_count           number of stored entries (0..DEPTH)
//   o_full, o_empty   occupancy flags decoded from the registered count
module pim_cmd_fifo #(
  parameter int WIDTH = 52,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             push_en, pop_en;

  assign o_full  = (count_q == CW'(DEPTH));
  assign o_empty = (count_q == '0);
  assign o_count = count_q;
  assign o_rdata = mem_q[rd_ptr_q];

  assign push_en = i_push && !o_full;
  assign pop_en  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = i_wdata;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({push_en, pop_en})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: the count and pointers decide what is valid.
  always_ff @(posedge i_clk) begin
    mem_q <= mem_d;
  end

endmodule

// File: rtl/pim_cmd_queue.sv
// Queues PIM commands from the core and issues them one at a time to the DMA,
// dropping and counting illegal commands and flagging a DMA that never starts.
// Ports:
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_cmd_valid / o_cmd_ready    command handshake (ready = FIFO not full)
//   i_funct3..i_mem_addr         incoming command fields
//   o_dma_en                     one-cycle start pulse to the DMA
//   o_funct3..o_mem_addr         fields of the command being issued
//   i_dma_busy                   DMA busy status
//   o_fifo_count                 commands waiting in the queue
//   o_pim_idle                   queue empty, FSM idle, DMA not busy
//   o_err_cnt                    saturating count of dropped illegal commands
//   o_timeout                    sticky: DMA never reported busy after a start
//   i_err_clr                    clears o_err_cnt and o_timeout
//
// state        | meaning
// ST_IDLE      | waiting for a queued command and a free DMA; pops the head
// ST_ISSUE     | start pulse on o_dma_en, busy timer loaded
// ST_WAIT_BUSY | waiting for the DMA to raise busy, timer counting down
// ST_WAIT_DONE | DMA running, waiting for busy to fall
module pim_cmd_queue
  import pim_pkg::*;
#(
  parameter int DEPTH        = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_cmd_valid,
  output logic                   o_cmd_ready,
  input  logic [2:0]             i_funct3,
  input  logic [3:0]             i_sel_pim,
  input  logic [12:0]            i_size,
  input  logic [31:0]            i_mem_addr,
  output logic                   o_dma_en,
  output logic [2:0]             o_funct3,
  output logic [3:0]             o_sel_pim,
  output logic [12:0]            o_size,
  output logic [31:0]            o_mem_addr,
  input  logic                   i_dma_busy,
  output logic [$clog2(DEPTH):0] o_fifo_count,
  output logic                   o_pim_idle,
  output logic [7:0]             o_err_cnt,
  output logic                   o_timeout,
  input  logic                   i_err_clr
);

  localparam int CW = $clog2(DEPTH) + 1;
  // The timer holds BUSY_TIMEOUT-1 down to 0, giving BUSY_TIMEOUT WAIT_BUSY cycles.
  localparam int TW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'(BUSY_TIMEOUT - 1);

  pim_cmd_t      in_cmd, head_cmd, cmd_q, cmd_d;
  pim_state_t    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    err_cnt_q, err_cnt_d;
  logic          timeout_q, timeout_d, timeout_set;
  logic          fifo_full, fifo_empty;
  logic          accept, cmd_legal, push, pop;
  logic [CW-1:0] fifo_count;

  always_comb begin
    in_cmd.funct3   = i_funct3;
    in_cmd.sel_pim  = i_sel_pim;
    in_cmd.size     = i_size;
    in_cmd.mem_addr = i_mem_addr;
  end

  assign o_cmd_ready = !fifo_full && !i_rst;
  assign accept      = i_cmd_valid && o_cmd_ready;
  assign cmd_legal   = pim_cmd_legal(i_funct3, i_size);
  // Illegal commands complete the handshake but never reach the FIFO.
  assign push        = accept && cmd_legal;

  pim_cmd_fifo #(
    .WIDTH (CMD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (push),
    .i_wdata (in_cmd),
    .i_pop   (pop),
    .o_rdata (head_cmd),
    .o_count (fifo_count),
    .o_full  (fifo_full),
    .o_empty (fifo_empty)
  );

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    timer_d     = timer_q;
    pop         = 1'b0;
    timeout_set = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!fifo_empty && !i_dma_busy) begin
          pop     = 1'b1;
          cmd_d   = head_cmd;
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        timer_d = TIMER_LOAD;
        state_d = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        if (i_dma_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (timer_q == '0) begin
          timeout_set = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!i_dma_busy) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Clear wins over a same-cycle increment or timeout.
  always_comb begin
    err_cnt_d = err_cnt_q;
    timeout_d = timeout_q;
    if (i_err_clr) begin
      err_cnt_d = '0;
      timeout_d = 1'b0;
    end else begin
      if (accept && !cmd_legal && (err_cnt_q != 8'hFF)) begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
      if (timeout_set) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_IDLE;
      cmd_q     <= '0;
      timer_q   <= '0;
      err_cnt_q <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      timer_q   <= timer_d;
      err_cnt_q <= err_cnt_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_dma_en     = (state_q == ST_ISSUE);
  assign o_funct3     = cmd_q.funct3;
  assign o_sel_pim    = cmd_q.sel_pim;
  assign o_size       = cmd_q.size;
  assign o_mem_addr   = cmd_q.mem_addr;
  assign o_fifo_count = fifo_count;
  assign o_pim_idle   = fifo_empty && (state_q == ST_IDLE) && !i_dma_busy;
  assign o_err_cnt    = err_cnt_q;
  assign o_timeout    = timeout_q;

endmodule

// File: tb/tb_pim_cmd_queue.sv
module tb_pim_cmd_queue;

  localparam int DEPTH        = 4;
  localparam int BUSY_TIMEOUT = 15;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_cmd_valid = 1'b0;
  logic        o_cmd_ready;
  logic [2:0]  i_funct3 = '0;
  logic [3:0]  i_sel_pim = '0;
  logic [12:0] i_size = '0;
  logic [31:0] i_mem_addr = '0;
  logic        o_dma_en;
  logic [2:0]  o_funct3;
  logic [3:0]  o_sel_pim;
  logic [12:0] o_size;
  logic [31:0] o_mem_addr;
  logic        i_dma_busy;
  logic [$clog2(DEPTH):0] o_fifo_count;
  logic        o_pim_idle;
  logic [7:0]  o_err_cnt;
  logic        o_timeout;
  logic        i_err_clr = 1'b0;

  // DMA model: either forced busy, or busy for busy_len cycles after each start.
  logic dma_force = 1'b0;
  logic dma_auto_en = 1'b1;
  logic dma_auto_busy = 1'b0;
  int   auto_cnt = 0;
  int   busy_len = 10;
  assign i_dma_busy = dma_force | dma_auto_busy;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [51:0] exp_q[$];
  int          model_err = 0;
  int          n_issued = 0;
  int          issue_cyc[$];
  int          last_acc_cyc = 0;
  int          timeout_rise_cyc = -1;
  logic        prev_timeout = 1'b0;
  logic        prev_rst = 1'b1;
  logic [51:0] prev_fields = '0;
  logic [51:0] last_fields = '0;

  pim_cmd_queue #(.DEPTH(DEPTH), .BUSY_TIMEOUT(BUSY_TIMEOUT)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_cmd_valid  (i_cmd_valid),
    .o_cmd_ready  (o_cmd_ready),
    .i_funct3     (i_funct3),
    .i_sel_pim    (i_sel_pim),
    .i_size       (i_size),
    .i_mem_addr   (i_mem_addr),
    .o_dma_en     (o_dma_en),
    .o_funct3     (o_funct3),
    .o_sel_pim    (o_sel_pim),
    .o_size       (o_size),
    .o_mem_addr   (o_mem_addr),
    .i_dma_busy   (i_dma_busy),
    .o_fifo_count (o_fifo_count),
    .o_pim_idle   (o_pim_idle),
    .o_err_cnt    (o_err_cnt),
    .o_timeout    (o_timeout),
    .i_err_clr    (i_err_clr)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  function automatic bit tb_legal(input logic [2:0] f3, input logic [12:0] sz);
    bit op;
    op = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b101) || (f3 == 3'b110);
    return op && (sz != 0);
  endfunction

  // Reference model and per-cycle comparison, sampled mid-cycle.
  always @(negedge i_clk) begin
    logic [51:0] cur;
    cyc++;
    cur = {o_funct3, o_sel_pim, o_size, o_mem_addr};
    if (o_dma_en) begin
      issue_cyc.push_back(cyc);
      n_issued++;
      last_fields = cur;
      check("dma_en_while_busy", i_dma_busy, 1'b0);
      check("issue_has_pending", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        check("issue_order_fields", cur, exp_q[0]);
        exp_q.delete(0);
      end
    end else if (!prev_rst) begin
      check("fields_hold", cur, prev_fields);
    end
    check("err_cnt", o_err_cnt, model_err);
    if (o_timeout && !prev_timeout) timeout_rise_cyc = cyc;
    prev_timeout = o_timeout;
    prev_fields  = cur;
    prev_rst     = i_rst;

    if (i_rst) begin
      exp_q.delete();
      model_err = 0;
    end else begin
      if (i_cmd_valid && o_cmd_ready) begin
        last_acc_cyc = cyc;
        if (tb_legal(i_funct3, i_size)) exp_q.push_back({i_funct3, i_sel_pim, i_size, i_mem_addr});
        else if (model_err < 255) model_err++;
      end
      if (i_err_clr) model_err = 0;
    end

    if (o_dma_en && dma_auto_en) auto_cnt = busy_len + 1;
    else if (auto_cnt > 0) auto_cnt--;
    dma_auto_busy = (auto_cnt != 0) && !o_dma_en;
  end

  task automatic send(input logic [2:0] f3, input logic [3:0] sel, input logic [12:0] sz, input logic [31:0] addr);
    int w;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b1;
    i_funct3 = f3; i_sel_pim = sel; i_size = sz; i_mem_addr = addr;
    for (w = 0; w < 200; w++) begin
      @(negedge i_clk);
      if (o_cmd_ready) break;
    end
    if (w == 200) check("send_accept_timeout", o_cmd_ready, 1'b1);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int w;
    for (w = 0; w < budget; w++) begin
      @(negedge i_clk);
      if (o_pim_idle && exp_q.size() == 0) break;
    end
    if (w == budget) check("wait_idle_timeout", o_pim_idle, 1'b1);
  endtask

  task automatic pulse_clr();
    @(posedge i_clk); #1 i_err_clr = 1'b1;
    @(posedge i_clk); #1 i_err_clr = 1'b0;
  endtask

  initial begin
    int base;

    // Reset values
    repeat (2) @(negedge i_clk);
    check("rst_ready", o_cmd_ready, 1'b0);
    check("rst_dma_en", o_dma_en, 1'b0);
    check("rst_fields", {o_funct3, o_sel_pim, o_size, o_mem_addr}, 52'h0);
    check("rst_err_cnt", o_err_cnt, 8'd0);
    check("rst_timeout", o_timeout, 1'b0);
    check("rst_count", o_fifo_count, 3'd0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    @(negedge i_clk);
    check("ready_after_rst", o_cmd_ready, 1'b1);

    // Single command: latency and fields
    busy_len = 10;
    base = n_issued;
    send(3'b001, 4'd3, 13'd8, 32'h100);
    wait_idle(100);
    @(negedge i_clk);
    check("single_issued", n_issued - base, 1);
    if (n_issued > base) check("single_latency", issue_cyc[base] - last_acc_cyc, 2);
    check("single_fields", last_fields, {3'b001, 4'd3, 13'd8, 32'h100});
    check("single_idle", o_pim_idle, 1'b1);

    // Fill with busy held high
    @(posedge i_clk); #1 dma_force = 1'b1;
    base = n_issued;
    send(3'b010, 4'd1, 13'd16, 32'h1000);
    send(3'b100, 4'd2, 13'd32, 32'h2000);
    send(3'b101, 4'd4, 13'd64, 32'h3000);
    send(3'b110, 4'd5, 13'd128, 32'h4000);
    @(negedge i_clk);
    check("fill_ready_low", o_cmd_ready, 1'b0);
    check("fill_count", o_fifo_count, 3'd4);
    check("fill_none_issued", n_issued - base, 0);
    @(posedge i_clk); #1 dma_force = 1'b0;
    send(3'b001, 4'd6, 13'd256, 32'h5000);
    wait_idle(400);
    check("fill_issued", n_issued - base, 5);
    check("fill_last_fields", last_fields, {3'b001, 4'd6, 13'd256, 32'h5000});

    // Illegal commands
    base = n_issued;
    send(3'b011, 4'd1, 13'd4, 32'h200);
    send(3'b001, 4'd2, 13'd0, 32'h300);
    repeat (5) @(negedge i_clk);
    check("illegal_not_issued", n_issued - base, 0);
    check("illegal_err_cnt", o_err_cnt, 8'd2);
    check("illegal_count", o_fifo_count, 3'd0);
    pulse_clr();
    @(negedge i_clk);
    check("err_clr", o_err_cnt, 8'd0);

    // Timeout: DMA never reports busy
    @(posedge i_clk); #1 dma_auto_en = 1'b0;
    check("timeout_init", o_timeout, 1'b0);
    timeout_rise_cyc = -1;
    base = n_issued;
    send(3'b010, 4'd5, 13'd16, 32'h400);
    send(3'b100, 4'd6, 13'd32, 32'h500);
    wait_idle(200);
    check("timeout_flag", o_timeout, 1'b1);
    check("timeout_issued", n_issued - base, 2);
    if (n_issued - base >= 2) begin
      check("timeout_at", timeout_rise_cyc - issue_cyc[base], 16);
      check("timeout_next_issue", issue_cyc[base+1] - issue_cyc[base], 17);
    end
    pulse_clr();
    @(negedge i_clk);
    check("timeout_clr", o_timeout, 1'b0);
    @(posedge i_clk); #1 dma_auto_en = 1'b1;

    // Reset during WAIT_DONE with 3 commands queued
    busy_len = 40;
    send(3'b111, 4'd0, 13'd1, 32'h0);
    send(3'b001, 4'd1, 13'd1, 32'h10);
    send(3'b010, 4'd2, 13'd2, 32'h20);
    send(3'b100, 4'd3, 13'd3, 32'h30);
    send(3'b101, 4'd4, 13'd4, 32'h40);
    repeat (2) @(negedge i_clk);
    check("rst_mid_count", o_fifo_count, 3'd3);
    check("rst_mid_busy", i_dma_busy, 1'b1);
    check("rst_mid_err_pre", o_err_cnt, 8'd1);
    @(posedge i_clk); #1 i_rst = 1'b1;
    @(negedge i_clk);
    check("rst_mid_ready", o_cmd_ready, 1'b0);
    @(negedge i_clk);
    check("rst_mid_dma_en", o_dma_en, 1'b0);
    check("rst_mid_fields", {o_funct3, o_sel_pim, o_size, o_mem_addr}, 52'h0);
    check("rst_mid_err", o_err_cnt, 8'd0);
    check("rst_mid_timeout", o_timeout, 1'b0);
    check("rst_mid_fifo", o_fifo_count, 3'd0);
    @(posedge i_clk); #1 i_rst = 1'b0;
    base = n_issued;
    repeat (60) @(negedge i_clk);
    check("rst_mid_no_reissue", n_issued - base, 0);
    check("rst_mid_idle", o_pim_idle, 1'b1);

    // Saturation, then clear beating a same-cycle increment
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b1; i_funct3 = 3'b011; i_size = 13'd1;
    repeat (260) @(posedge i_clk);
    #1 i_cmd_valid = 1'b0;
    @(negedge i_clk);
    check("sat_err_cnt", o_err_cnt, 8'd255);
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b1; i_err_clr = 1'b1;
    @(posedge i_clk); #1;
    i_cmd_valid = 1'b0; i_err_clr = 1'b0;
    @(negedge i_clk);
    check("clr_priority", o_err_cnt, 8'd0);

    repeat (3) @(negedge i_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/pim_cmd_queue.md
PIM_CMD_QUEUE -- requirements
Module: pim_cmd_queue

Interface
REQ-001 Parameter DEPTH, default 4, command FIFO depth; power of two, 2..16.
REQ-002 Parameter BUSY_TIMEOUT, default 15, maximum cycles to wait for DMA busy after issue.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 i_clk  in  1  clock.
REQ-005 i_rst  in  1  synchronous active-high reset.
REQ-006 i_cmd_valid  in  1  core presents a PIM command.
REQ-007 o_cmd_ready  out  1  queue accepts the command this cycle.
REQ-008 i_funct3 / i_sel_pim / i_size / i_mem_addr  in  3/4/13/32  command fields.
REQ-009 o_dma_en  out  1  one-cycle start pulse to the DMA.
REQ-010 o_funct3 / o_sel_pim / o_size / o_mem_addr  out  3/4/13/32  fields of the issued command.
REQ-011 i_dma_busy  in  1  DMA busy status.
REQ-012 o_fifo_count  out  $clog2(DEPTH)+1  stored commands.
REQ-013 o_pim_idle  out  1  FIFO empty, FSM in IDLE, i_dma_busy low.
REQ-014 o_err_cnt  out  8  saturating count of dropped illegal commands.
REQ-015 o_timeout  out  1  sticky flag: DMA never reported busy.
REQ-016 i_err_clr  in  1  clears o_err_cnt and o_timeout.

Function
REQ-017 Handshake: accept when i_cmd_valid && o_cmd_ready; o_cmd_ready = FIFO not full; no bypass path.
REQ-018 Legal funct3: 001 write, 010 compute, 100 load, 101 key, 110 vref; any other funct3, or i_size==0, is illegal.
REQ-019 An accepted illegal command is consumed but not stored; o_err_cnt increments, saturating at 255.
REQ-020 Simultaneous push and pop leave the count unchanged; a pop on an empty FIFO never occurs.
REQ-021 FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
REQ-022 IDLE: when the FIFO is non-empty and i_dma_busy is low, pop the head, register its fields onto the o_* outputs, and go to ISSUE.
REQ-023 ISSUE: o_dma_en=1 for exactly one cycle; next state WAIT_BUSY.
REQ-024 WAIT_BUSY: on i_dma_busy=1 go to WAIT_DONE; after BUSY_TIMEOUT cycles without busy, set o_timeout and go to IDLE.
REQ-025 WAIT_DONE: on i_dma_busy=0 go to IDLE.
REQ-026 The o_* fields hold stable from ISSUE through the return to IDLE.
REQ-027 Latency: command accepted at cycle T into an empty, idle queue produces o_dma_en=1 at T+2.
REQ-028 Back-to-back: the next o_dma_en comes no earlier than 2 cycles after i_dma_busy falls.
REQ-029 Commands issue strictly in FIFO order; o_dma_en is never asserted while i_dma_busy=1.
REQ-030 i_err_clr has priority over a same-cycle increment and over a same-cycle timeout set.

Reset
REQ-031 Reset empties the FIFO and puts the FSM in IDLE.
REQ-032 Reset values: o_dma_en=0, o_* fields=0, o_err_cnt=0, o_timeout=0, o_fifo_count=0.
REQ-033 During reset o_cmd_ready=0; afterwards it equals !full.
REQ-034 Reset mid-transfer aborts tracking; queued commands are discarded and nothing is re-issued.

Structure
REQ-035 Shared package pim_pkg: funct3 constants, the command struct (52 bits), the FSM state enum and the legality function.
REQ-036 One sub-module, pim_cmd_fifo: synchronous FIFO with parameterised width and depth, registered count, and full/empty flags.

Verification
REQ-037 Single command: write, sel 3, size 8, addr 0x100 accepted at T -> o_dma_en at T+2 with exactly those fields; model busy 10 cycles -> o_pim_idle=1 afterwards.
REQ-038 Fill: 5 valid commands with DEPTH=4 and busy held high -> o_cmd_ready low after 4 accepts; the commands issue in order as busy toggles.
REQ-039 Illegal commands: funct3=011, then funct3=001 with size 0 -> neither is issued; o_err_cnt=2; i_err_clr -> 0.
REQ-040 Timeout: the DMA model never asserts busy -> o_timeout=1 at ISSUE+1+15 cycles; the next queued command is then issued.
REQ-041 Reset asserted in WAIT_DONE with 3 commands queued -> all outputs at reset values next cycle; no o_dma_en after release.
REQ-042 Saturation: 260 illegal commands -> o_err_cnt=255.
